// File: rtl/mult_issue_pkg.sv
// Shared types and constants for the multiplier issue arbiter slice.
// Optional same-cycle CDB bypass is enabled with MULT_ISSUE_ARB_BYPASS_EN.
package mult_issue_pkg;

    localparam int unsigned MULT_LAT   = 4;
    localparam int unsigned MULT_TAG_W = 6;

    typedef logic [MULT_TAG_W-1:0] tag_t;

    typedef struct packed {
        tag_t        tag;
        logic [63:0] value;
    } mult_res_t;

endpackage

// File: rtl/mult_res_fifo.sv
// Completed-result buffer: circular FIFO of {tag, product} with an occupancy count.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module mult_res_fifo
    import mult_issue_pkg::*;
#(
    parameter  int unsigned DEPTH = 6,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  mult_res_t        push_data,
    input  logic             pop,
    output mult_res_t        head,
    output logic [CNT_W-1:0] count
);

    mult_res_t        mem_q [DEPTH];
    mult_res_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_pop   = pop && (cnt_q != '0);
        do_push  = push && ((cnt_q < CNT_W'(DEPTH)) || do_pop);
        if (clr) begin
            // Pointers realign on flush so the next push lands at the head.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = cnt_q;

endmodule

// File: rtl/mult_issue_arb.sv
// Round-robin issue of operand pairs to a shared pipelined multiplier, tag shadow pipe,
// credit-limited result buffer to the CDB. Define MULT_ISSUE_ARB_BYPASS_EN for same-cycle bypass.
module mult_issue_arb
    import mult_issue_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned TAG_W      = 6,
    parameter int unsigned LAT        = MULT_LAT,
    parameter int unsigned OBUF_DEPTH = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*64-1:0]    req_mplier,
    input  logic [NUM_REQ*64-1:0]    req_mcand,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic [NUM_REQ-1:0]       req_grant,
    input  logic                     squash,
    output logic                     mult_start,
    output logic [63:0]              mult_mplier,
    output logic [63:0]              mult_mcand,
    input  logic [63:0]              mult_product,
    input  logic                     mult_done,
    output logic                     cdb_req,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [63:0]              cdb_value,
    input  logic                     cdb_grant
);

    localparam int unsigned RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned OCC_W = $clog2(OBUF_DEPTH + 1);
    localparam int unsigned CNT_W = $clog2(OBUF_DEPTH + 1);

    logic [RR_W-1:0]  rr_q, rr_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    logic             iss_valid_q, iss_valid_d;
    logic [63:0]      iss_mplier_q, iss_mplier_d;
    logic [63:0]      iss_mcand_q, iss_mcand_d;
    logic [TAG_W-1:0] iss_tag_q, iss_tag_d;

    logic [LAT-1:0]   sh_valid_q, sh_valid_d;
    logic [TAG_W-1:0] sh_tag_q [LAT];
    logic [TAG_W-1:0] sh_tag_d [LAT];

    logic             grant_any;
    logic [63:0]      sel_mplier;
    logic [63:0]      sel_mcand;
    logic [TAG_W-1:0] sel_tag;

    logic             comp_valid;
    mult_res_t        comp_res;
    mult_res_t        fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             pop_any;

    // Round-robin search from rr_q; credit and squash gate the whole grant.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        req_grant  = '0;
        grant_any  = 1'b0;
        rr_d       = rr_q;
        sel_mplier = '0;
        sel_mcand  = '0;
        sel_tag    = '0;
        if (reset && !squash && (occ_q < OCC_W'(OBUF_DEPTH))) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                idx = (int'(rr_q) + k) % NUM_REQ;
                if (!grant_any && req_valid[idx]) begin
                    grant_any      = 1'b1;
                    req_grant[idx] = 1'b1;
                    rr_d           = RR_W'((idx + 1) % NUM_REQ);
                    sel_mplier     = req_mplier[idx*64 +: 64];
                    sel_mcand      = req_mcand[idx*64 +: 64];
                    sel_tag        = req_tag[idx*TAG_W +: TAG_W];
                end
            end
        end
    end

    always_comb begin
        iss_valid_d  = grant_any;
        iss_mplier_d = grant_any ? sel_mplier : iss_mplier_q;
        iss_mcand_d  = grant_any ? sel_mcand  : iss_mcand_q;
        iss_tag_d    = grant_any ? sel_tag    : iss_tag_q;

        sh_valid_d[0] = iss_valid_q && !squash;
        sh_tag_d[0]   = iss_tag_q;
        for (int unsigned k = 1; k < LAT; k++) begin
            sh_valid_d[k] = sh_valid_q[k-1] && !squash;
            sh_tag_d[k]   = sh_tag_q[k-1];
        end
    end

    assign mult_start  = iss_valid_q;
    assign mult_mplier = iss_mplier_q;
    assign mult_mcand  = iss_mcand_q;

    always_comb begin
        comp_valid     = mult_done && sh_valid_q[LAT-1];
        comp_res.tag   = tag_t'(sh_tag_q[LAT-1]);
        comp_res.value = mult_product;
        fifo_empty     = (fifo_count == '0);
        fifo_pop       = cdb_grant && !fifo_empty;
`ifdef MULT_ISSUE_ARB_BYPASS_EN
        // Completion into an empty buffer is offered directly; accepted ones skip the write.
        cdb_req   = !fifo_empty || comp_valid;
        cdb_tag   = fifo_empty ? sh_tag_q[LAT-1] : TAG_W'(fifo_head.tag);
        cdb_value = fifo_empty ? mult_product    : fifo_head.value;
        fifo_push = comp_valid && !(fifo_empty && cdb_grant);
`else
        cdb_req   = !fifo_empty;
        cdb_tag   = TAG_W'(fifo_head.tag);
        cdb_value = fifo_head.value;
        fifo_push = comp_valid;
`endif
        pop_any   = cdb_req && cdb_grant;
        occ_d     = squash ? '0 : occ_q + OCC_W'(grant_any) - OCC_W'(pop_any);
    end

    mult_res_fifo #(
        .DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clk       (clock),
        .rst_n     (reset),
        .clr       (squash),
        .push      (fifo_push),
        .push_data (comp_res),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_q         <= '0;
            occ_q        <= '0;
            iss_valid_q  <= 1'b0;
            iss_mplier_q <= '0;
            iss_mcand_q  <= '0;
            iss_tag_q    <= '0;
            sh_valid_q   <= '0;
            sh_tag_q     <= '{default: '0};
        end else begin
            rr_q         <= rr_d;
            occ_q        <= occ_d;
            iss_valid_q  <= iss_valid_d;
            iss_mplier_q <= iss_mplier_d;
            iss_mcand_q  <= iss_mcand_d;
            iss_tag_q    <= iss_tag_d;
            sh_valid_q   <= sh_valid_d;
            sh_tag_q     <= sh_tag_d;
        end
    end

`ifndef SYNTHESIS
    // Starts not yet answered by the multiplier, squashed ones included.
    logic [7:0] sim_pend_q, sim_pend_d;

    always_comb begin
        sim_pend_d = sim_pend_q + 8'(mult_start) - 8'(mult_done);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sim_pend_q <= '0;
        end else begin
            sim_pend_q <= sim_pend_d;
            assert (!(mult_done && (sim_pend_q == '0)))
                else $error("mult_issue_arb: mult_done with no outstanding mult_start");
        end
    end
`endif

endmodule

// File: tb/tb_mult_issue_arb.sv
// Scoreboard bench for mult_issue_arb with a 4-stage multiplier model.
// Honours MULT_ISSUE_ARB_BYPASS_EN for the expected result latency.
module tb_mult_issue_arb;

    localparam int NREQ  = 2;
    localparam int TW    = 6;
    localparam int DEPTH = 6;
`ifdef MULT_ISSUE_ARB_BYPASS_EN
    localparam int RES_LAT = 5;
`else
    localparam int RES_LAT = 6;
`endif

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*64-1:0]   req_mplier;
    logic [NREQ*64-1:0]   req_mcand;
    logic [NREQ*TW-1:0]   req_tag;
    logic [NREQ-1:0]      req_grant;
    logic                 squash;
    logic                 mult_start;
    logic [63:0]          mult_mplier;
    logic [63:0]          mult_mcand;
    logic [63:0]          mult_product;
    logic                 mult_done;
    logic                 cdb_req;
    logic [TW-1:0]        cdb_tag;
    logic [63:0]          cdb_value;
    logic                 cdb_grant;

    mult_issue_arb #(
        .NUM_REQ    (NREQ),
        .TAG_W      (TW),
        .LAT        (4),
        .OBUF_DEPTH (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_mplier   (req_mplier),
        .req_mcand    (req_mcand),
        .req_tag      (req_tag),
        .req_grant    (req_grant),
        .squash       (squash),
        .mult_start   (mult_start),
        .mult_mplier  (mult_mplier),
        .mult_mcand   (mult_mcand),
        .mult_product (mult_product),
        .mult_done    (mult_done),
        .cdb_req      (cdb_req),
        .cdb_tag      (cdb_tag),
        .cdb_value    (cdb_value),
        .cdb_grant    (cdb_grant)
    );

    always #5 clock = ~clock;

    // External multiplier: start in cycle s gives done in cycle s+4.
    logic [63:0] mp_q [4];
    logic        mv_q [4];
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                mv_q[i] <= 1'b0;
                mp_q[i] <= '0;
            end
        end else begin
            mv_q[0] <= mult_start;
            mp_q[0] <= mult_mplier * mult_mcand;
            for (int i = 1; i < 4; i++) begin
                mv_q[i] <= mv_q[i-1];
                mp_q[i] <= mp_q[i-1];
            end
        end
    end
    assign mult_done    = mv_q[3];
    assign mult_product = mp_q[3];

    typedef struct {
        logic [TW-1:0] tag;
        logic [63:0]   val;
        int            ready;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   mon_en   = 0;

    // Reference model state: round-robin pointer and last issue.
    int          rr_m = 0;
    bit          exp_start = 0;
    logic [63:0] exp_a = '0, exp_b = '0;
    bit          sq_prev = 0;

    // Per-cycle stimulus.
    logic [NREQ-1:0] st_valid;
    logic [63:0]     st_a [NREQ];
    logic [63:0]     st_b [NREQ];
    logic [TW-1:0]   st_t [NREQ];
    logic            st_sq, st_cg;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            st_a[i] = rnd64();
            st_b[i] = rnd64();
            st_t[i] = TW'($urandom());
        end
    endtask

    task automatic set_idle(input logic cg);
        st_valid = '0;
        st_sq    = 1'b0;
        st_cg    = cg;
    endtask

    task automatic step();
        int gi;
        logic [NREQ-1:0] exp_g;
        @(posedge clock);
        cyc++;
        #1;
        if (sq_prev) sb.delete();
        reset      = 1'b1;
        req_valid  = st_valid;
        req_mplier = {st_a[1], st_a[0]};
        req_mcand  = {st_b[1], st_b[0]};
        req_tag    = {st_t[1], st_t[0]};
        squash     = st_sq;
        cdb_grant  = st_cg;
        #3;
        chk("mult_start", 64'(mult_start), 64'(exp_start));
        if (exp_start) begin
            chk("mult_mplier", mult_mplier, exp_a);
            chk("mult_mcand", mult_mcand, exp_b);
        end
        gi    = -1;
        exp_g = '0;
        if (!st_sq && sb.size() < DEPTH) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (rr_m + k) % NREQ;
                if (gi < 0 && st_valid[idx]) gi = idx;
            end
        end
        if (gi >= 0) begin
            exp_g[gi] = 1'b1;
            rr_m      = (gi + 1) % NREQ;
            sb.push_back('{tag: st_t[gi], val: st_a[gi] * st_b[gi], ready: cyc + RES_LAT});
            exp_a = st_a[gi];
            exp_b = st_b[gi];
        end
        chk("req_grant", 64'(req_grant), 64'(exp_g));
        exp_start = (gi >= 0);
        sq_prev   = st_sq;
    endtask

    // Result monitor: every presented-and-accepted result is matched to the oldest expected one.
    always @(negedge clock) begin
        if (mon_en) begin
            bit exp_req;
            exp_req = (sb.size() > 0) && (sb[0].ready <= cyc);
            chk("cdb_req", 64'(cdb_req), 64'(exp_req));
            if (cdb_req && cdb_grant) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL cdb_pop cyc=%0d: got tag %0h value %0h, expected no result", cyc, cdb_tag, cdb_value);
                end else begin
                    chk("cdb_tag", 64'(cdb_tag), 64'(sb[0].tag));
                    chk("cdb_value", cdb_value, sb[0].val);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        reset      = 1'b0;
        req_valid  = 2'b11;
        req_mplier = '0;
        req_mcand  = '0;
        req_tag    = '0;
        squash     = 1'b0;
        cdb_grant  = 1'b0;
        rand_ops();
        set_idle(1'b1);

        repeat (3) begin
            @(posedge clock);
            #4;
            chk("rst_req_grant", 64'(req_grant), 64'd0);
            chk("rst_cdb_req", 64'(cdb_req), 64'd0);
            chk("rst_mult_start", 64'(mult_start), 64'd0);
            chk("rst_cdb_tag", 64'(cdb_tag), 64'd0);
            chk("rst_cdb_value", cdb_value, 64'd0);
        end
        mon_en = 1;

        // First grant after reset goes to requester 0.
        st_valid = 2'b11;
        step();
        set_idle(1'b1);
        repeat (8) step();

        // Single op: 7 * 6, tag 5.
        st_a[0] = 64'd7; st_b[0] = 64'd6; st_t[0] = 6'd5;
        st_valid = 2'b01;
        step();
        set_idle(1'b1);
        repeat (8) step();

        // Round robin with an always-ready CDB.
        st_valid = 2'b11;
        st_cg    = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rand_ops();
            step();
        end
        set_idle(1'b1);
        repeat (8) step();

        // Backpressure: credits run out after DEPTH grants, then drain.
        st_valid = 2'b11;
        st_cg    = 1'b0;
        for (int i = 0; i < 14; i++) begin
            rand_ops();
            step();
        end
        set_idle(1'b1);
        repeat (12) step();

        // Squash in the cycle after three grants, then a fresh op.
        st_valid = 2'b11;
        st_cg    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            step();
        end
        st_sq = 1'b1;
        step();
        set_idle(1'b1);
        step();
        rand_ops();
        st_valid = 2'b10;
        step();
        set_idle(1'b1);
        repeat (10) step();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rand_ops();
            st_valid = NREQ'($urandom());
            st_cg    = ($urandom_range(3) != 0);
            st_sq    = ($urandom_range(31) == 0);
            step();
        end

        set_idle(1'b1);
        repeat (20) step();
        chk("drain_empty", 64'(sb.size()), 64'd0);
        mon_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
